spi_packet_decoder: RTL and testbench
=====================================

# spi_packet_decoder

Packet layer directly downstream of the SPI secondary word engine. It consumes the one-cycle `word_ready` pulse and `data_word_received` byte, decodes command packets, and assembles motion payloads into wide words for the motion FIFO over a valid/ready handshake. It also drives `data_word_to_send` with a live status byte, which the host clocks back on the following SPI word.

## Interface
- `PayloadBytes`, default 8: bytes per motion payload; legal range 1..32.
- `WordBits`, default 8: SPI word width; must equal the secondary's `WordBits`. Only 8 is supported.
- `clk`  input  1  system clock, shared with the SPI secondary.
- `rst`  input  1  reset; synchronous, active-high.
- `cs`  input  1  channel select, same signal as the secondary's; high = deselected, aborts any partial packet.
- `word_ready`  input  1  one-cycle pulse: new byte valid on `data_word_received`.
- `data_word_received`  input  WordBits  byte just received.
- `data_word_to_send`  output  WordBits  status byte, continuously driven (registered).
- `payload_valid`  output  1  assembled payload available.
- `payload_ready`  input  1  downstream accepts payload when high together with `payload_valid`.
- `payload_data`  output  PayloadBytes*8  assembled payload; byte 0 in bits [7:0] (little-endian).

## Operation
- Opcodes, taken from the header byte:
  - 0x00 NOP
  - 0x01 WRITE_MOTION (followed by PayloadBytes bytes)
  - 0x02 READ_STATUS (no payload)
  - 0x03 CLEAR_FLAGS (clears `err` and `ovf`)
  - any other value is illegal: sets `err` and the packet is ignored.
- FSM states: HEADER, PAYLOAD.
  - HEADER + `word_ready` + 0x01 -> PAYLOAD, byte counter := 0.
  - PAYLOAD + `word_ready` -> store byte at index counter, counter++.
  - When counter reaches PayloadBytes-1 on a `word_ready` -> commit, return to HEADER.
  - All other headers stay in HEADER.
- Commit rules:
  - Holding register empty, or being drained the same cycle (`payload_valid & payload_ready`): load the assembly buffer into `payload_data`, set `payload_valid`, `pkt_cnt` increments (mod 32).
  - Holding register full and not draining: packet dropped, `ovf` set, `pkt_cnt` unchanged.
- `payload_valid` stays high and `payload_data` stays stable until `payload_ready`. This is a single holding register; no deeper buffering.
- Status byte = {`payload_valid`, `err`, `ovf`, `pkt_cnt[4:0]`}. It is recomputed every cycle from registered state and registered again onto `data_word_to_send`.
- `cs` high in any state -> FSM to HEADER and counter := 0. The partial payload is discarded and no flag is set. The holding register and flags are unaffected.
- `word_ready` while `cs` high is ignored.
- CLEAR_FLAGS coinciding with an overflow-causing commit cannot occur, because they are different states.

## Timing
- Reset values:
  - state HEADER, counter 0
  - `payload_valid` 0, `payload_data` 0
  - `err` 0, `ovf` 0, `pkt_cnt` 0
  - `data_word_to_send` 0x00
- `word_ready` at cycle t: state, counter and flag updates are visible at t+1.
- Final payload byte `word_ready` at t: `payload_valid` = 1 at t+1.
- Handshake: the transfer occurs on any cycle with `payload_valid & payload_ready`. `payload_valid` drops at the next cycle unless a new commit happens in the same cycle, in which case it stays 1 with the new data.
- `data_word_to_send` lags state by 1 cycle. Any flag change made at t+1 from a `word_ready` at t is visible at t+2. The secondary samples it at its next `word_ready`, which is ≥8 SCK edges later, so there is no hazard.
- `rst` mid-packet: everything returns to reset values on the next edge, including a pending payload.

## Structure
- Shared package `spi_pkg`:
  - opcode enum `spi_opcode_e` (NOP, WRITE_MOTION, READ_STATUS, CLEAR_FLAGS)
  - `spi_status_t` packed struct (`valid`, `err`, `ovf`, `pkt_cnt[4:0]`)
  - state enum.
- Single module, no sub-modules. Top level instantiates `spi_secondary` and `spi_packet_decoder` side by side.
- Counter width $clog2(PayloadBytes); assembly buffer is PayloadBytes×8 bits.

## Test plan
- Reset then idle: `data_word_to_send` = 0x00, `payload_valid` = 0.
- PayloadBytes=8, `payload_ready`=1; send 0x01, 0x11..0x88:
  - `payload_data` = 0x8877665544332211, `payload_valid` pulses 1 cycle after the last `word_ready`
  - status then reads 0x01.
- `payload_ready`=0; send two full WRITE_MOTION packets:
  - first payload held
  - second dropped, status = 0xA1 (valid, ovf, cnt=1)
  - then 0x03 -> status 0x81.
- Header 0x7F -> `err` set, status 0x40. Next header 0x01 still decodes normally.
- 0x01 + 3 bytes, then `cs` high for 1 cycle, then full packet 0x01, 0xA0..0xA7:
  - exactly one payload, equal to 0xA7A6A5A4A3A2A1A0
  - no flags set.
- Commit coinciding with a drain: `payload_valid` stays 1, new data appears, `pkt_cnt` advances to 2, `ovf` stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI packet layer: opcodes, status byte layout and decoder states.
package spi_pkg;

    typedef enum logic [7:0] {
        OP_NOP          = 8'h00,
        OP_WRITE_MOTION = 8'h01,
        OP_READ_STATUS  = 8'h02,
        OP_CLEAR_FLAGS  = 8'h03
    } spi_opcode_e;

    // Bit order matches the byte returned to the host: {valid, err, ovf, pkt_cnt}.
    typedef struct packed {
        logic       valid;
        logic       err;
        logic       ovf;
        logic [4:0] pkt_cnt;
    } spi_status_t;

    typedef enum logic {
        ST_HEADER  = 1'b0,
        ST_PAYLOAD = 1'b1
    } dec_state_e;

endpackage

// File: rtl/spi_packet_decoder.sv
// Decodes SPI command packets, assembles WRITE_MOTION payloads into a single holding
// register and returns a registered status byte to the host.
module spi_packet_decoder
    import spi_pkg::*;
#(
    parameter int PayloadBytes = 8,
    parameter int WordBits     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cs,
    input  logic                      word_ready,
    input  logic [WordBits-1:0]       data_word_received,
    output logic [WordBits-1:0]       data_word_to_send,
    output logic                      payload_valid,
    input  logic                      payload_ready,
    output logic [PayloadBytes*8-1:0] payload_data
);

    localparam int CntW  = (PayloadBytes > 1) ? $clog2(PayloadBytes) : 1;
    localparam int DataW = PayloadBytes * 8;
    localparam logic [CntW-1:0] LastIdx = CntW'(PayloadBytes - 1);

    // Handshake: a payload transfers on every cycle where payload_valid and payload_ready
    // are both high; payload_valid/payload_data hold steady until that happens.

    dec_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [DataW-1:0] asm_q, asm_d;
    logic [DataW-1:0] hold_q, hold_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;
    logic [4:0]       pkt_cnt_q, pkt_cnt_d;
    logic             drain;
    logic             commit;
    spi_status_t      status;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        err_d     = err_q;
        ovf_d     = ovf_q;
        pkt_cnt_d = pkt_cnt_q;
        commit    = 1'b0;
        drain     = valid_q & payload_ready;

        if (cs) begin
            // Deselect drops any partial packet silently; holding register and flags survive.
            state_d = ST_HEADER;
            cnt_d   = '0;
        end else if (word_ready) begin
            unique case (state_q)
                ST_HEADER: begin
                    if (data_word_received == OP_WRITE_MOTION) begin
                        state_d = ST_PAYLOAD;
                        cnt_d   = '0;
                    end else if (data_word_received == OP_CLEAR_FLAGS) begin
                        err_d = 1'b0;
                        ovf_d = 1'b0;
                    end else if (data_word_received != OP_NOP &&
                                 data_word_received != OP_READ_STATUS) begin
                        err_d = 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    for (int i = 0; i < PayloadBytes; i++) begin
                        if (cnt_q == CntW'(i)) asm_d[i*8 +: 8] = data_word_received[7:0];
                    end
                    if (cnt_q == LastIdx) begin
                        commit  = 1'b1;
                        state_d = ST_HEADER;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_HEADER;
            endcase
        end

        if (drain) valid_d = 1'b0;

        // A draining holding register counts as empty, so back-to-back commits never stall.
        if (commit) begin
            if (!valid_q || drain) begin
                hold_d    = asm_d;
                valid_d   = 1'b1;
                pkt_cnt_d = pkt_cnt_q + 5'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        status.valid   = valid_q;
        status.err     = err_q;
        status.ovf     = ovf_q;
        status.pkt_cnt = pkt_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_HEADER;
            cnt_q             <= '0;
            asm_q             <= '0;
            hold_q            <= '0;
            valid_q           <= 1'b0;
            err_q             <= 1'b0;
            ovf_q             <= 1'b0;
            pkt_cnt_q         <= '0;
            data_word_to_send <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            asm_q             <= asm_d;
            hold_q            <= hold_d;
            valid_q           <= valid_d;
            err_q             <= err_d;
            ovf_q             <= ovf_d;
            pkt_cnt_q         <= pkt_cnt_d;
            data_word_to_send <= WordBits'(status);
        end
    end

    assign payload_valid = valid_q;
    assign payload_data  = hold_q;

endmodule

// File: tb/tb_spi_packet_decoder.sv
// Bench for spi_packet_decoder: directed packet table, hand-written corner sequences
// and randomized traffic against a queue-based packet model.
module tb_spi_packet_decoder;

    localparam int PB = 8;
    localparam int DW = PB * 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs = 1'b1;
    logic          word_ready = 1'b0;
    logic [7:0]    data_word_received = 8'h00;
    logic [7:0]    data_word_to_send;
    logic          payload_valid;
    logic          payload_ready = 1'b0;
    logic [DW-1:0] payload_data;

    int vectors = 0;
    int miscompares = 0;

    spi_packet_decoder #(.PayloadBytes(PB), .WordBits(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .cs                 (cs),
        .word_ready         (word_ready),
        .data_word_received (data_word_received),
        .data_word_to_send  (data_word_to_send),
        .payload_valid      (payload_valid),
        .payload_ready      (payload_ready),
        .payload_data       (payload_data)
    );

    always #5 clk = ~clk;

    // Reference model: bytes of the open packet collected in a queue.
    logic          m_in_pkt;
    logic [7:0]    pkt_q[$];
    logic          m_valid, m_err, m_ovf;
    logic [4:0]    m_cnt;
    logic [DW-1:0] m_hold;
    logic [7:0]    exp_status;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_pkt = 1'b0;
        pkt_q.delete();
        m_valid = 1'b0;
        m_err = 1'b0;
        m_ovf = 1'b0;
        m_cnt = 5'd0;
        m_hold = '0;
        exp_status = 8'h00;
    endtask

    task automatic model_step(input logic c, input logic w, input logic [7:0] b, input logic r);
        logic          commit;
        logic          drained;
        logic [DW-1:0] word;
        commit = 1'b0;
        word = '0;
        drained = m_valid && r;
        if (c) begin
            m_in_pkt = 1'b0;
            pkt_q.delete();
        end else if (w) begin
            if (m_in_pkt) begin
                pkt_q.push_back(b);
                if (pkt_q.size() == PB) begin
                    for (int i = 0; i < PB; i++) word = word | (DW'(pkt_q[i]) << (8 * i));
                    commit = 1'b1;
                    pkt_q.delete();
                    m_in_pkt = 1'b0;
                end
            end else if (b == 8'h01) begin
                m_in_pkt = 1'b1;
            end else if (b == 8'h03) begin
                m_err = 1'b0;
                m_ovf = 1'b0;
            end else if (b > 8'h03) begin
                m_err = 1'b1;
            end
        end
        if (drained) m_valid = 1'b0;
        if (commit) begin
            if (!m_valid) begin
                m_valid = 1'b1;
                m_hold = word;
                m_cnt = m_cnt + 5'd1;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    // One clock: drive at negedge, predict the upcoming posedge, compare at next negedge.
    task automatic tick(input logic c, input logic w, input logic [7:0] b, input logic r);
        cs = c;
        word_ready = w;
        data_word_received = b;
        payload_ready = r;
        exp_status = {m_valid, m_err, m_ovf, m_cnt};
        model_step(c, w, b, r);
        @(negedge clk);
        chk("model_valid", DW'(payload_valid), DW'(m_valid));
        chk("model_status", DW'(data_word_to_send), DW'(exp_status));
        if (m_valid) chk("model_data", payload_data, m_hold);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cs = 1'b1;
        word_ready = 1'b0;
        payload_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("reset_valid", DW'(payload_valid), DW'(1'b0));
        chk("reset_status", DW'(data_word_to_send), DW'(8'h00));
        chk("reset_data", payload_data, '0);
    endtask

    task automatic send_pkt(input logic [7:0] base, input logic [7:0] step, input logic r);
        tick(1'b0, 1'b1, 8'h01, r);
        for (int i = 0; i < PB; i++) tick(1'b0, 1'b1, 8'(base + step * 8'(i)), r);
    endtask

    typedef struct {
        logic          do_rst;
        logic          send_hdr;
        logic [7:0]    hdr;
        int            n;
        logic [7:0]    base;
        logic [7:0]    step;
        logic          abort;
        logic          rdy;
        logic          exp_valid;
        logic [7:0]    exp_status;
        logic          chk_data;
        logic [DW-1:0] exp_data;
    } row_t;

    row_t rows[11];

    initial begin
        rows[0]  = '{1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 64'h0};
        rows[1]  = '{1, 1, 8'h01, 8, 8'h11, 8'h11, 0, 0, 1, 8'h81, 1, 64'h8877665544332211};
        rows[2]  = '{0, 1, 8'h01, 8, 8'h21, 8'h01, 0, 0, 1, 8'hA1, 1, 64'h8877665544332211};
        rows[3]  = '{0, 1, 8'h03, 0, 8'h00, 8'h00, 0, 0, 1, 8'h81, 1, 64'h8877665544332211};
        rows[4]  = '{1, 1, 8'h7F, 0, 8'h00, 8'h00, 0, 0, 0, 8'h40, 0, 64'h0};
        rows[5]  = '{0, 1, 8'h01, 8, 8'h31, 8'h01, 0, 0, 1, 8'hC1, 1, 64'h3837363534333231};
        rows[6]  = '{1, 1, 8'h01, 3, 8'h51, 8'h01, 1, 0, 0, 8'h00, 0, 64'h0};
        rows[7]  = '{0, 1, 8'h01, 8, 8'hA0, 8'h01, 0, 0, 1, 8'h81, 1, 64'hA7A6A5A4A3A2A1A0};
        rows[8]  = '{0, 1, 8'h02, 0, 8'h00, 8'h00, 0, 0, 1, 8'h81, 1, 64'hA7A6A5A4A3A2A1A0};
        rows[9]  = '{0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 8'h81, 1, 64'hA7A6A5A4A3A2A1A0};
        rows[10] = '{0, 1, 8'h03, 0, 8'h00, 8'h00, 0, 1, 0, 8'h01, 0, 64'h0};

        @(negedge clk);
        do_reset();

        // Single packet with payload_ready high: one-cycle valid pulse.
        send_pkt(8'h11, 8'h11, 1'b1);
        chk("pulse_valid_hi", DW'(payload_valid), DW'(1'b1));
        chk("pulse_data", payload_data, 64'h8877665544332211);
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        chk("pulse_valid_lo", DW'(payload_valid), DW'(1'b0));
        repeat (2) tick(1'b0, 1'b0, 8'h00, 1'b1);
        chk("pulse_status", DW'(data_word_to_send), DW'(8'h01));

        // Packet-level table.
        foreach (rows[k]) begin
            if (rows[k].do_rst) do_reset();
            if (rows[k].send_hdr) tick(1'b0, 1'b1, rows[k].hdr, rows[k].rdy);
            for (int i = 0; i < rows[k].n; i++)
                tick(1'b0, 1'b1, 8'(rows[k].base + rows[k].step * 8'(i)), rows[k].rdy);
            if (rows[k].abort) tick(1'b1, 1'b0, 8'h00, rows[k].rdy);
            repeat (3) tick(1'b0, 1'b0, 8'h00, rows[k].rdy);
            chk($sformatf("row%0d_valid", k), DW'(payload_valid), DW'(rows[k].exp_valid));
            chk($sformatf("row%0d_status", k), DW'(data_word_to_send), DW'(rows[k].exp_status));
            if (rows[k].chk_data) chk($sformatf("row%0d_data", k), payload_data, rows[k].exp_data);
        end

        // Commit on the same cycle the held payload drains.
        do_reset();
        send_pkt(8'h11, 8'h11, 1'b0);
        tick(1'b0, 1'b1, 8'h01, 1'b0);
        for (int i = 0; i < PB - 1; i++) tick(1'b0, 1'b1, 8'(8'hB0 + 8'(i)), 1'b0);
        tick(1'b0, 1'b1, 8'hB7, 1'b1);
        chk("drain_commit_valid", DW'(payload_valid), DW'(1'b1));
        chk("drain_commit_data", payload_data, 64'hB7B6B5B4B3B2B1B0);
        repeat (2) tick(1'b0, 1'b0, 8'h00, 1'b0);
        chk("drain_commit_status", DW'(data_word_to_send), DW'(8'h82));

        // Reset while a payload is pending and a packet is half-assembled.
        tick(1'b0, 1'b1, 8'h01, 1'b0);
        tick(1'b0, 1'b1, 8'h55, 1'b0);
        do_reset();
        repeat (2) tick(1'b0, 1'b0, 8'h00, 1'b0);
        chk("midrst_status", DW'(data_word_to_send), DW'(8'h00));

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            logic       c, w, r;
            logic [7:0] b;
            c = ($urandom_range(0, 39) == 0);
            w = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 3) == 0);
            if (m_in_pkt) begin
                b = 8'($urandom_range(0, 255));
            end else begin
                case ($urandom_range(0, 7))
                    0: b = 8'h00;
                    1, 2, 3: b = 8'h01;
                    4: b = 8'h02;
                    5: b = 8'h03;
                    default: b = 8'($urandom_range(4, 255));
                endcase
            end
            if ($urandom_range(0, 999) == 0) do_reset();
            else tick(c, w, b, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
